// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared constants for the word memory: default geometry and the R_W select
// encodings used by the controller-facing bus.
//
// Optional feature macro used by the importing files: MEMORY_WRITE_THROUGH_EN
// -----------------------------------------------------------------------------
package memory_pkg;

    // Default geometry: 2^8 words of 32 bits.
    localparam int MEM_WIDTH_DEF      = 8;
    localparam int MEM_DIN_LENGTH_DEF = 32;

    // R_W select encodings.
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage : memory_pkg

// File: rtl/memory_array.sv
// -----------------------------------------------------------------------------
// memory_array
// Register-based storage of 2^WIDTH words of DinLength bits. The whole array
// is cleared asynchronously by rst_i. One synchronous write port and one
// combinational read port.
//
// Ports:
//   clk_i    - rising-edge clock
//   rst_i    - asynchronous active-high clear of every word
//   we_i     - write enable (sampled on the rising edge)
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - combinational read data (mem[raddr_i])
// -----------------------------------------------------------------------------
module memory_array
    import memory_pkg::*;
#(
    parameter int WIDTH     = MEM_WIDTH_DEF,
    parameter int DinLength = MEM_DIN_LENGTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [WIDTH-1:0]     waddr_i,
    input  logic [DinLength-1:0] wdata_i,
    input  logic [WIDTH-1:0]     raddr_i,
    output logic [DinLength-1:0] rdata_o
);

    localparam int DEPTH = 1 << WIDTH;

    logic [DinLength-1:0] mem_q [DEPTH];

    // Every word is cleared by reset so unwritten locations read back as 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Address covers the full depth, so no range check is needed.
    assign rdata_o = mem_q[raddr_i];

endmodule : memory_array

// File: rtl/memory.sv
// -----------------------------------------------------------------------------
// memory
// Single-port synchronous word memory, 2^WIDTH words of DinLength bits.
// Valid qualifies each access; R_W selects write (1) or read (0). Reads load
// the registered output Dout on the same edge that samples Addr. Reset is
// asynchronous and clears both the array and Dout.
//
// Ports:
//   Clk    - rising-edge clock
//   Reset  - asynchronous active-high reset (array and Dout)
//   Din    - write data
//   Addr   - word address
//   R_W    - 1 = write, 0 = read
//   Valid  - access request qualifier, no access when 0
//   Dout   - registered read data
//
// Configuration macro:
//   MEMORY_WRITE_THROUGH_EN - when defined, a write also loads Din into Dout.
//                             When undefined, Dout holds during writes.
// -----------------------------------------------------------------------------
module memory
    import memory_pkg::*;
#(
    parameter int WIDTH     = MEM_WIDTH_DEF,
    parameter int DinLength = MEM_DIN_LENGTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [DinLength-1:0] Din,
    input  logic [WIDTH-1:0]     Addr,
    input  logic                 R_W,
    input  logic                 Valid,
    output logic [DinLength-1:0] Dout
);

    logic                 wr_en;
    logic                 rd_en;
    logic [DinLength-1:0] rdata;
    logic [DinLength-1:0] dout_d;
    logic [DinLength-1:0] dout_q;

    assign wr_en = Valid && (R_W == RW_WRITE);
    assign rd_en = Valid && (R_W == RW_READ);

    memory_array #(
        .WIDTH     (WIDTH),
        .DinLength (DinLength)
    ) u_array (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .we_i    (wr_en),
        .waddr_i (Addr),
        .wdata_i (Din),
        .raddr_i (Addr),
        .rdata_o (rdata)
    );

    // Dout only moves on a qualified read (or a write, in write-through builds).
    always_comb begin
        dout_d = dout_q;
        if (rd_en) begin
            dout_d = rdata;
        end
`ifdef MEMORY_WRITE_THROUGH_EN
        else if (wr_en) begin
            dout_d = Din;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign Dout = dout_q;

endmodule : memory

// File: tb/tb_memory.sv
// -----------------------------------------------------------------------------
// tb_memory
// Directed self-checking bench for the word memory. Expected values are
// hand-computed constants. Build with or without MEMORY_WRITE_THROUGH_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_memory;

    logic        Clk;
    logic        Reset;
    logic [31:0] Din;
    logic [7:0]  Addr;
    logic        R_W;
    logic        Valid;
    logic [31:0] Dout;

    int total = 0;
    int bad   = 0;

    memory #(
        .WIDTH     (8),
        .DinLength (32)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Din   (Din),
        .Addr  (Addr),
        .R_W   (R_W),
        .Valid (Valid),
        .Dout  (Dout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

`ifdef MEMORY_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one access, let it hit a rising edge, sample 1ns later.
    task automatic acc(input logic v, input logic rw, input logic [7:0] a, input logic [31:0] d);
        Valid = v;
        R_W   = rw;
        Addr  = a;
        Din   = d;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset at t=0 with a write request held across the reset edges.
        Reset = 1'b1;
        Valid = 1'b1;
        R_W   = 1'b1;
        Addr  = 8'd0;
        Din   = 32'hAABBCCDD;
        #1;
        chk("reset_dout_t0", Dout, 32'h0);
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_dout_held", Dout, 32'h0);

        // Release: the held write lands on the first edge after release.
        Reset = 1'b0;
        acc(1'b1, 1'b1, 8'd0, 32'hAABBCCDD);
        chk("first_write_dout", Dout, WT ? 32'hAABBCCDD : 32'h0);
        acc(1'b1, 1'b0, 8'd0, 32'h0);
        chk("read_addr0", Dout, 32'hAABBCCDD);

        // Three writes on consecutive edges, then reads in reverse order.
        acc(1'b1, 1'b1, 8'd1, 32'h11223344);
        acc(1'b1, 1'b1, 8'd2, 32'h55667788);
        acc(1'b1, 1'b1, 8'd3, 32'h99AABBCC);
        chk("dout_after_writes", Dout, WT ? 32'h99AABBCC : 32'hAABBCCDD);
        acc(1'b1, 1'b0, 8'd3, 32'h0);
        chk("read_addr3", Dout, 32'h99AABBCC);
        acc(1'b1, 1'b0, 8'd2, 32'h0);
        chk("read_addr2", Dout, 32'h55667788);
        acc(1'b1, 1'b0, 8'd1, 32'h0);
        chk("read_addr1", Dout, 32'h11223344);

        // Unwritten location reads zero.
        acc(1'b1, 1'b0, 8'd4, 32'h0);
        chk("read_unwritten4", Dout, 32'h0);

        // Bring a nonzero value onto Dout, then reset mid-cycle.
        acc(1'b1, 1'b0, 8'd1, 32'h0);
        chk("reread_addr1", Dout, 32'h11223344);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_dout", Dout, 32'h0);
        // Access requested across a reset edge must be discarded.
        Valid = 1'b1;
        R_W   = 1'b1;
        Addr  = 8'd9;
        Din   = 32'hCAFEF00D;
        @(posedge Clk);
        #1;
        chk("reset_hold_dout", Dout, 32'h0);
        Reset = 1'b0;
        acc(1'b1, 1'b0, 8'd1, 32'h0);
        chk("read_addr1_after_reset", Dout, 32'h0);
        acc(1'b1, 1'b0, 8'd3, 32'h0);
        chk("read_addr3_after_reset", Dout, 32'h0);
        acc(1'b1, 1'b0, 8'd9, 32'h0);
        chk("discarded_write9", Dout, 32'h0);

        // Valid=0 must neither write nor disturb Dout.
        acc(1'b1, 1'b1, 8'd6, 32'h0BADF00D);
        acc(1'b1, 1'b0, 8'd6, 32'h0);
        chk("read_addr6", Dout, 32'h0BADF00D);
        acc(1'b0, 1'b1, 8'd5, 32'hDEADBEEF);
        chk("invalid_write_dout_hold", Dout, 32'h0BADF00D);
        acc(1'b0, 1'b0, 8'd0, 32'h0);
        chk("invalid_read_dout_hold", Dout, 32'h0BADF00D);
        acc(1'b1, 1'b0, 8'd5, 32'h0);
        chk("read_addr5_not_written", Dout, 32'h0);

        // Write then read-after-write on consecutive edges.
        acc(1'b1, 1'b1, 8'd7, 32'h12345678);
        chk("write7_dout", Dout, WT ? 32'h12345678 : 32'h0);
        acc(1'b1, 1'b0, 8'd7, 32'h0);
        chk("raw_addr7", Dout, 32'h12345678);

        // Top of the address range.
        acc(1'b1, 1'b1, 8'd255, 32'hFFFFFFFF);
        acc(1'b1, 1'b0, 8'd255, 32'h0);
        chk("read_addr255", Dout, 32'hFFFFFFFF);
        acc(1'b1, 1'b0, 8'd0, 32'h0);
        chk("read_addr0_cleared", Dout, 32'h0);
        acc(1'b1, 1'b0, 8'd6, 32'h0);
        chk("reread_addr6", Dout, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_memory
